game_flow_fsm: RTL and testbench
================================

# game_flow_fsm

Top-level game-flow sequencer that consumes the sticky `player1_dead`/`player2_dead` flags raised by the hazard controllers (water, lava, goo) and the door-reached flags, and drives the round lifecycle: title, play, death animation, retry, win and game-over. It issues the single-cycle `level_reset` that clears the hazard and player modules, freezes player motion outside active play, and tracks lives and an optional round timer. It sits between the hazard/door logic and the player, physics and HUD blocks.

## Interface
Parameters:
- `DEATH_FRAMES`, 90: frame ticks spent in the death animation.
- `LIVES`, 3: lives at game start, 1..3.
- `FRAMES_PER_SEC`, 60: frame ticks per timer second.
- `TIME_LIMIT`, 180: round time in seconds, 1..255.

Ports:
- `Clk`  in  1  system clock; the block's only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_clk`  in  1  raw VGA vsync-rate frame clock; asynchronous to `Clk`.
- `start`  in  1  start/confirm key, level; rising edge used.
- `player1_dead`, `player2_dead`  in  1 each  sticky death flags from the hazard controllers.
- `player1_at_door`, `player2_at_door`  in  1 each  player inside its exit door.
- `level_reset`  out  1  one-`Clk` pulse that resets hazards and player positions.
- `freeze`  out  1  high while player motion is inhibited.
- `game_state`  out  3  0 IDLE, 1 PLAY, 2 DYING, 3 WIN, 4 GAMEOVER.
- `lives_left`  out  2  remaining lives.
- `time_left`  out  8  remaining seconds.
- `dead_mask`  out  2  latched cause of death: bit0 player1, bit1 player2, 11 on timeout.

## Operation
- `frame_clk` passes through a 2-flop synchronizer. `frame_tick` is an internal one-cycle pulse on the synchronized 0→1 edge.
- `start` is registered once. `start_edge` is asserted when the current value is 1 and the registered value is 0.
- **IDLE**: `freeze`=1. On `start_edge`:
  - pulse `level_reset`;
  - set `lives_left`=LIVES, `time_left`=TIME_LIMIT, `dead_mask`=0;
  - go to PLAY.
- **PLAY**: `freeze`=0. A 2-cycle blanking counter starts on every PLAY entry. While it is nonzero, dead, door and timeout conditions are ignored, giving the hazard modules time to clear their sticky flags. After blanking, checks are made every cycle in this priority order:
  1. Either dead flag: latch `dead_mask`={p2_dead,p1_dead}, `lives_left` -= 1 (saturating at 0), go to DYING.
  2. Both door flags: go to WIN.
  3. `time_left`==0: `dead_mask`=11, `lives_left` -= 1, go to DYING.
- **DYING**: `freeze`=1. The frame counter is cleared on entry and counts `frame_tick`s. When it reaches DEATH_FRAMES:
  - if `lives_left`==0, go to GAMEOVER;
  - otherwise pulse `level_reset`, set `time_left`=TIME_LIMIT and `dead_mask`=0, and re-enter PLAY.
- **WIN**, **GAMEOVER**: `freeze`=1; outputs hold. `start_edge` returns to IDLE; no `level_reset` is issued.
- Timer: only in PLAY, a sub-second counter counts `frame_tick`s modulo FRAMES_PER_SEC. On wrap, `time_left` decrements, saturating at 0. The sub-second counter clears whenever `level_reset` pulses.
- Dead and door inputs are ignored in every state except PLAY after blanking.
- Unused `game_state` codes 5–7 return to IDLE on the next cycle.

## Timing
- Reset values: `game_state`=IDLE, `freeze`=1, `level_reset`=0, `lives_left`=LIVES, `time_left`=TIME_LIMIT, `dead_mask`=0. All counters and synchronizers are 0.
- Reset is asynchronous: it takes effect immediately, including mid-DYING or mid-PLAY.
- `level_reset` is registered. It is high for exactly the one cycle in which `game_state` first reads PLAY.
- `start` → PLAY: IDLE changes to PLAY on the edge after the cycle in which `start_edge` is high.
- Dead input → DYING: a dead flag sampled high in cycle N (post-blanking) gives `game_state`=DYING, `dead_mask` and `lives_left` updated, all visible in cycle N+1.
- `frame_clk` rise → `frame_tick`: 3 `Clk` edges.
- Simultaneous dead and both-at-door in the same cycle: DYING wins.
- `start_edge` during PLAY or DYING is ignored.

## Configuration
- `GAME_TIMER_EN` defined: the round timer runs as described and timeout kills both players.
- `GAME_TIMER_EN` undefined: the sub-second counter and timeout logic are removed, and `time_left` is constant at TIME_LIMIT.

## Test plan
- Reset, then `start` rising edge: one-cycle `level_reset` with `game_state`=1 in the same cycle, `lives_left`=3, `time_left`=180, `freeze`=0 after entry.
- `player1_dead` raised 10 cycles into PLAY: next cycle `game_state`=2, `dead_mask`=01, `lives_left`=2. After 90 `frame_tick`s: `level_reset` pulse, `game_state`=1, `dead_mask`=00.
- Three deaths in a row, with the dead flag held high through the first 2 PLAY cycles each time: the flag is ignored during blanking. After the third animation `game_state`=4 and `lives_left`=0; a `start` edge gives `game_state`=0.
- Both door flags high with `player2_dead` high in the same cycle: `game_state`=2, `dead_mask`=10. With door flags only: `game_state`=3.
- `GAME_TIMER_EN` defined, TIME_LIMIT=2, FRAMES_PER_SEC=4: 8 `frame_tick`s in PLAY bring `time_left` to 0, then next cycle `game_state`=2 with `dead_mask`=11.
- `Reset` asserted mid-DYING (frame counter at 40): outputs return to reset values asynchronously, with no `level_reset` pulse.

Source files
------------

// File: rtl/game_flow_fsm.sv
// Round lifecycle sequencer: title, play, death animation, retry, win, game over.
// Optional round timer enabled by defining GAME_TIMER_EN.
module game_flow_fsm #(
  parameter int DEATH_FRAMES   = 90,
  parameter int LIVES          = 3,
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIME_LIMIT     = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_door,
  input  logic       player2_at_door,
  output logic       level_reset,
  output logic       freeze,
  output logic [2:0] game_state,
  output logic [1:0] lives_left,
  output logic [7:0] time_left,
  output logic [1:0] dead_mask
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_DYING    = 3'd2,
    S_WIN      = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam int             DW         = $clog2(DEATH_FRAMES + 1);
  localparam logic [DW-1:0]  DEATH_LAST = DW'(DEATH_FRAMES);
  localparam logic [1:0]     LIVES_INIT = 2'(LIVES);
  localparam logic [7:0]     TIME_INIT  = 8'(TIME_LIMIT);

  if (LIVES < 1 || LIVES > 3 || TIME_LIMIT < 1 || TIME_LIMIT > 255 ||
      FRAMES_PER_SEC < 1 || DEATH_FRAMES < 1) begin : g_param_check
    $error("game_flow_fsm: parameter out of range");
  end

  state_t        r_state;
  logic          r_level_reset;
  logic          r_freeze;
  logic [1:0]    r_lives;
  logic [7:0]    r_time;
  logic [1:0]    r_dead_mask;
  logic [1:0]    r_blank;
  logic [DW-1:0] r_death_cnt;
  logic [2:0]    r_fsync;
  logic          r_frame_tick;
  logic          r_start;
  logic          w_start_edge;
  logic          w_any_dead;
  logic          w_both_door;

`ifdef GAME_TIMER_EN
  localparam int              SUB_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(FRAMES_PER_SEC - 1);
  logic [SUB_W-1:0] r_sub;
`endif

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : 2'(v - 2'd1);
  endfunction

  assign w_start_edge = start & ~r_start;
  assign w_any_dead   = player1_dead | player2_dead;
  assign w_both_door  = player1_at_door & player2_at_door;

  // fsync[1:0] is the synchronizer; fsync[2] holds the previous synced value for edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fsync      <= 3'b000;
      r_frame_tick <= 1'b0;
      r_start      <= 1'b0;
    end else begin
      r_fsync      <= {r_fsync[1:0], frame_clk};
      r_frame_tick <= r_fsync[1] & ~r_fsync[2];
      r_start      <= start;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_level_reset <= 1'b0;
      r_freeze      <= 1'b1;
      r_lives       <= LIVES_INIT;
      r_time        <= TIME_INIT;
      r_dead_mask   <= 2'b00;
      r_blank       <= 2'd0;
      r_death_cnt   <= '0;
`ifdef GAME_TIMER_EN
      r_sub         <= '0;
`endif
    end else begin
      r_level_reset <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_freeze <= 1'b1;
          if (w_start_edge) begin
            r_state       <= S_PLAY;
            r_level_reset <= 1'b1;
            r_freeze      <= 1'b0;
            r_blank       <= 2'd2;
            r_lives       <= LIVES_INIT;
            r_time        <= TIME_INIT;
            r_dead_mask   <= 2'b00;
`ifdef GAME_TIMER_EN
            r_sub         <= '0;
`endif
          end
        end
        S_PLAY: begin
`ifdef GAME_TIMER_EN
          if (r_frame_tick) begin
            if (r_sub == SUB_LAST) begin
              r_sub <= '0;
              if (r_time != 8'd0) r_time <= r_time - 8'd1;
            end else begin
              r_sub <= r_sub + 1'b1;
            end
          end
`endif
          // Blanking lets the hazard blocks drop their sticky flags after level_reset
          if (r_blank != 2'd0) begin
            r_blank <= r_blank - 2'd1;
          end else if (w_any_dead) begin
            r_dead_mask <= {player2_dead, player1_dead};
            r_lives     <= sat_dec(r_lives);
            r_state     <= S_DYING;
            r_freeze    <= 1'b1;
            r_death_cnt <= '0;
          end else if (w_both_door) begin
            r_state  <= S_WIN;
            r_freeze <= 1'b1;
`ifdef GAME_TIMER_EN
          end else if (r_time == 8'd0) begin
            r_dead_mask <= 2'b11;
            r_lives     <= sat_dec(r_lives);
            r_state     <= S_DYING;
            r_freeze    <= 1'b1;
            r_death_cnt <= '0;
`endif
          end
        end
        S_DYING: begin
          r_freeze <= 1'b1;
          if (r_death_cnt == DEATH_LAST) begin
            if (r_lives == 2'd0) begin
              r_state <= S_GAMEOVER;
            end else begin
              r_state       <= S_PLAY;
              r_level_reset <= 1'b1;
              r_freeze      <= 1'b0;
              r_blank       <= 2'd2;
              r_time        <= TIME_INIT;
              r_dead_mask   <= 2'b00;
`ifdef GAME_TIMER_EN
              r_sub         <= '0;
`endif
            end
          end else if (r_frame_tick) begin
            r_death_cnt <= r_death_cnt + 1'b1;
          end
        end
        S_WIN, S_GAMEOVER: begin
          r_freeze <= 1'b1;
          if (w_start_edge) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_freeze <= 1'b1;
        end
      endcase
    end
  end

  assign level_reset = r_level_reset;
  assign freeze      = r_freeze;
  assign game_state  = r_state;
  assign lives_left  = r_lives;
  assign time_left   = r_time;
  assign dead_mask   = r_dead_mask;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed self-checking bench for game_flow_fsm (timer scenario only when GAME_TIMER_EN is defined).
module tb_game_flow_fsm;

`ifdef GAME_TIMER_EN
  localparam int TL  = 2;
  localparam int FPS = 4;
`else
  localparam int TL  = 180;
  localparam int FPS = 60;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0;
  logic       player1_dead = 1'b0;
  logic       player2_dead = 1'b0;
  logic       player1_at_door = 1'b0;
  logic       player2_at_door = 1'b0;
  logic       level_reset;
  logic       freeze;
  logic [2:0] game_state;
  logic [1:0] lives_left;
  logic [7:0] time_left;
  logic [1:0] dead_mask;

  int errors = 0;
  int checks = 0;

  game_flow_fsm #(
    .DEATH_FRAMES(90), .LIVES(3), .FRAMES_PER_SEC(FPS), .TIME_LIMIT(TL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .player1_dead(player1_dead), .player2_dead(player2_dead),
    .player1_at_door(player1_at_door), .player2_at_door(player2_at_door),
    .level_reset(level_reset), .freeze(freeze), .game_state(game_state),
    .lives_left(lives_left), .time_left(time_left), .dead_mask(dead_mask)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b0;
    cyc(4);
    frame_clk = 1'b1;
    cyc(4);
  endtask

  // 89 full frames, then the 90th rise; stop at the first cycle out of DYING
  task automatic run_anim();
    repeat (89) frame_pulse();
    chk("still_dying_89", {29'd0, game_state}, 32'd2);
    frame_clk = 1'b0;
    cyc(4);
    frame_clk = 1'b1;
    for (int i = 0; i < 20 && game_state == 3'd2; i++) @(negedge Clk);
    chk("left_dying", {31'd0, game_state != 3'd2}, 32'd1);
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {29'd0, game_state}, 32'd0);
    chk({tag, "_freeze"}, {31'd0, freeze}, 32'd1);
    chk({tag, "_lr"}, {31'd0, level_reset}, 32'd0);
    chk({tag, "_lives"}, {30'd0, lives_left}, 32'd3);
    chk({tag, "_time"}, {24'd0, time_left}, TL);
    chk({tag, "_mask"}, {30'd0, dead_mask}, 32'd0);
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk_reset_vals("rst");
    Reset = 1'b0;
    cyc(2);

    // Start: level_reset coincides with first PLAY cycle
    press_start();
    chk("start_state", {29'd0, game_state}, 32'd1);
    chk("start_lr", {31'd0, level_reset}, 32'd1);
    chk("start_lives", {30'd0, lives_left}, 32'd3);
    chk("start_time", {24'd0, time_left}, TL);
    chk("start_freeze", {31'd0, freeze}, 32'd0);
    cyc(1);
    chk("start_lr_drop", {31'd0, level_reset}, 32'd0);

    // Death 10 cycles into PLAY
    cyc(8);
    player1_dead = 1'b1;
    cyc(1);
    player1_dead = 1'b0;
    chk("d1_state", {29'd0, game_state}, 32'd2);
    chk("d1_mask", {30'd0, dead_mask}, 32'd1);
    chk("d1_lives", {30'd0, lives_left}, 32'd2);
    chk("d1_freeze", {31'd0, freeze}, 32'd1);
    run_anim();
    chk("a1_lr", {31'd0, level_reset}, 32'd1);
    chk("a1_state", {29'd0, game_state}, 32'd1);
    chk("a1_mask", {30'd0, dead_mask}, 32'd0);
    chk("a1_time", {24'd0, time_left}, TL);
    chk("a1_freeze", {31'd0, freeze}, 32'd0);

    // Second death: dead flag held through blanking is ignored
    player1_dead = 1'b1;
    cyc(1);
    chk("b2_cyc2", {29'd0, game_state}, 32'd1);
    cyc(1);
    player1_dead = 1'b0;
    chk("b2_cyc3", {29'd0, game_state}, 32'd1);
    cyc(3);
    chk("b2_alive", {29'd0, game_state}, 32'd1);
    press_start();
    chk("start_in_play", {29'd0, game_state}, 32'd1);
    player1_dead = 1'b1;
    cyc(1);
    player1_dead = 1'b0;
    chk("d2_state", {29'd0, game_state}, 32'd2);
    chk("d2_lives", {30'd0, lives_left}, 32'd1);
    run_anim();
    chk("a2_state", {29'd0, game_state}, 32'd1);

    // Third death ends the game
    player1_dead = 1'b1;
    cyc(2);
    player1_dead = 1'b0;
    cyc(3);
    chk("b3_alive", {29'd0, game_state}, 32'd1);
    player1_dead = 1'b1;
    cyc(1);
    player1_dead = 1'b0;
    chk("d3_lives", {30'd0, lives_left}, 32'd0);
    press_start();
    chk("start_in_dying", {29'd0, game_state}, 32'd2);
    run_anim();
    chk("go_state", {29'd0, game_state}, 32'd4);
    chk("go_lives", {30'd0, lives_left}, 32'd0);
    chk("go_lr", {31'd0, level_reset}, 32'd0);
    chk("go_freeze", {31'd0, freeze}, 32'd1);
    cyc(3);
    chk("go_hold", {29'd0, game_state}, 32'd4);
    press_start();
    chk("go_to_idle", {29'd0, game_state}, 32'd0);

    // Death beats door in the same cycle; doors alone give WIN
    cyc(2);
    press_start();
    cyc(5);
    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    player2_dead = 1'b1;
    cyc(1);
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    player2_dead = 1'b0;
    chk("dd_state", {29'd0, game_state}, 32'd2);
    chk("dd_mask", {30'd0, dead_mask}, 32'd2);
    chk("dd_lives", {30'd0, lives_left}, 32'd2);
    run_anim();
    cyc(5);
    player1_at_door = 1'b1;
    cyc(2);
    chk("one_door", {29'd0, game_state}, 32'd1);
    player2_at_door = 1'b1;
    cyc(1);
    chk("win_state", {29'd0, game_state}, 32'd3);
    chk("win_freeze", {31'd0, freeze}, 32'd1);
    press_start();
    chk("win_idle", {29'd0, game_state}, 32'd0);
    chk("win_no_lr", {31'd0, level_reset}, 32'd0);
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;

    // Asynchronous reset with death counter at 40
    cyc(2);
    press_start();
    cyc(4);
    player1_dead = 1'b1;
    cyc(1);
    player1_dead = 1'b0;
    chk("rd_state", {29'd0, game_state}, 32'd2);
    repeat (40) frame_pulse();
    #2 Reset = 1'b1;
    #1 chk_reset_vals("arst");
    cyc(1);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("arst_no_lr", {31'd0, level_reset}, 32'd0);
    end
    chk("arst_idle", {29'd0, game_state}, 32'd0);

`ifdef GAME_TIMER_EN
    // Timeout kills both players
    press_start();
    cyc(4);
    repeat (4) frame_pulse();
    chk("tmr_1s", {24'd0, time_left}, 32'd1);
    repeat (4) frame_pulse();
    chk("tmr_zero", {24'd0, time_left}, 32'd0);
    chk("tmr_still_play", {29'd0, game_state}, 32'd1);
    cyc(1);
    chk("tmr_state", {29'd0, game_state}, 32'd2);
    chk("tmr_mask", {30'd0, dead_mask}, 32'd3);
    chk("tmr_lives", {30'd0, lives_left}, 32'd2);
`else
    press_start();
    cyc(4);
    repeat (8) frame_pulse();
    chk("no_tmr_time", {24'd0, time_left}, TL);
    chk("no_tmr_play", {29'd0, game_state}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
